rr_mux_reg: RTL and testbench
=============================

Name: rr_mux_reg

Overview:
- Parametrised N-channel, WIDTH-bit selector that arbitrates among requesting sources itself rather than taking an external `sel`.
- Each source has a valid/ready handshake. A round-robin or fixed-priority arbiter picks one source and loads its word into a registered output stage.
- Sits between ALU result producers and the shared writeback/result bus.

Parameters:
- WIDTH, 32, data width per channel.
- N, 8, number of input channels (2..16, need not be a power of two).
- RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (channel 0 highest).
- SEL_W, $clog2(N), width of the source-index field (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel request.
- in_ready  output  N  per-channel accept; combinational.
- out_data  output  WIDTH  registered selected word.
- out_src  output  SEL_W  registered index of the channel that produced out_data.
- out_valid  output  1  registered; out_data/out_src are valid.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_src=0, rr pointer=0. While rst is high, in_ready=0 combinationally. Reset mid-transfer discards the held word; no transfer is counted.
- Load condition: load = !out_valid || out_ready. The output register accepts a new word only when load=1.
- Grant:
  - RR=1: the first channel with in_valid=1, searching from pointer upward and wrapping N-1 -> 0.
  - RR=0: the lowest-index valid channel.
  - Grant is combinational from in_valid and the pointer.
- in_ready[i] = load && any(in_valid) && (grant==i). At most one bit of in_ready is set; in_ready bits for non-valid channels are 0.
- Transfer on channel g when in_valid[g] && in_ready[g]. Next cycle: out_data=in_data[g], out_src=g, out_valid=1.
- Latency: 1 cycle from input handshake to out_valid. Throughput: 1 word/cycle while out_ready=1.
- If load=1 and no channel is valid: out_valid goes to 0 next cycle; out_data/out_src hold their last values.
- Backpressure: out_valid=1 && out_ready=0 holds out_data/out_src/out_valid stable and drives all in_ready to 0.
- Pointer (RR=1 only): after a transfer on g, pointer = g+1, wrapping g=N-1 -> 0. It is unchanged when there is no transfer. With RR=0 the pointer is held at 0.
- in_valid deasserting without a handshake is tolerated. Grant is re-evaluated every cycle.
- Non-power-of-2 N: pointer and out_src never take values >= N.

Optional Feature:
- Macro RR_MUX_REG_LOCK_EN.
- Defined:
  - Adds port in_last (input, N bits).
  - Once a channel is granted for a beat with in_last[g]=0, the grant is locked to g. Other channels get in_ready=0 until a beat with in_last[g]=1 transfers on g.
  - The pointer advances only on that last beat.
  - While locked and in_valid[g]=0, no transfer occurs even if other channels are valid.
  - Adds output out_last (registered, reset 0).
- Undefined: no in_last/out_last ports; every beat is arbitrated independently.

Decomposition:
- Package rr_mux_pkg:
  - function idx_w(n), returning max(1, clog2(n)).
  - Mode localparams MODE_FIXED=0, MODE_RR=1.
- Sub-module rr_arbiter (parameters N, RR):
  - Inputs: req[N], ptr, en.
  - Outputs: one-hot grant[N], grant index, any.
  - Purely combinational.
- The pointer register and output stage stay in rr_mux_reg.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=8'hFF -> in_ready=0, out_valid=0, out_data=0, out_src=0. First cycle after release: in_ready=8'h01.
- Round-robin sweep (N=8, RR=1, out_ready=1, in_valid=8'hFF, in_data[i]=32'hA000_0000+i): out_src goes 0,1,...,7,0 on consecutive cycles; out_data matches each source.
- Backpressure: with out_valid=1 and out_src=3, drop out_ready for 4 cycles -> out_data/out_src stable and in_ready=0. Raise out_ready -> channel 4 is granted in the same cycle.
- Sparse/wrap: pointer=6, in_valid=8'b0000_0101 -> grant 0, then 2. in_valid=0 with out_ready=1 -> out_valid=0 next cycle.
- Fixed priority (RR=0, N=5): in_valid=5'b11010 held -> out_src=1 every cycle; channels 3 and 4 are never granted.
- LOCK_EN: channel 2 sends 3 beats (in_last=0,0,1) with channel 5 continuously valid -> out_src=2,2,2, then 5. Pointer=3 after the last beat of channel 2.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Shared constants and helpers for the arbitrating result mux.
package rr_mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_mux_reg_arb.sv
// Combinational round-robin / fixed-priority arbiter; grant is one-hot and gated by en.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int N     = 8,
  parameter int RR    = MODE_RR,
  parameter int SEL_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] gidx,
  output logic             any
);

  logic [SEL_W:0] c;
  logic [SEL_W:0] base;

  assign base = (RR == MODE_RR) ? {1'b0, ptr} : '0;

  // Walk channels starting at base, wrapping at N; the first requester wins.
  always_comb begin
    gidx = '0;
    any  = 1'b0;
    c    = '0;
    for (int k = 0; k < N; k++) begin
      c = base + (SEL_W+1)'(k);
      if (c >= (SEL_W+1)'(N)) c = c - (SEL_W+1)'(N);
      if (!any && req[c[SEL_W-1:0]]) begin
        any  = 1'b1;
        gidx = c[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++)
      grant[i] = en && any && (gidx == SEL_W'(i));
  end

endmodule

// File: rtl/rr_mux_reg.sv
// N-channel arbitrating mux with registered output stage.
// Optional burst locking via RR_MUX_REG_LOCK_EN (adds in_last / out_last).
module rr_mux_reg
  import rr_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 8,
  parameter int RR    = MODE_RR,
  parameter int SEL_W = idx_w(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
`ifdef RR_MUX_REG_LOCK_EN
  input  logic [N-1:0]       in_last,
  output logic               out_last,
`endif
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_src,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] gidx;
  logic [N-1:0]     req;
  logic             any, load, en, xfer, beat_last;

  assign load = !out_valid || out_ready;
  assign en   = load && !rst;
  assign xfer = en && any;

`ifdef RR_MUX_REG_LOCK_EN
  logic             locked;
  logic [SEL_W-1:0] lock_ch;

  // While a burst is open only the owning channel may request.
  always_comb begin
    req = in_valid;
    if (locked) begin
      req          = '0;
      req[lock_ch] = in_valid[lock_ch];
    end
  end
  assign beat_last = in_last[gidx];
`else
  assign req       = in_valid;
  assign beat_last = 1'b1;
`endif

  rr_arbiter #(.N(N), .RR(RR), .SEL_W(SEL_W)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .en    (en),
    .grant (in_ready),
    .gidx  (gidx),
    .any   (any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
`ifdef RR_MUX_REG_LOCK_EN
      locked    <= 1'b0;
      lock_ch   <= '0;
      out_last  <= 1'b0;
`endif
    end else begin
      if (load) out_valid <= xfer;
      if (xfer) begin
        out_data <= in_data[gidx*WIDTH +: WIDTH];
        out_src  <= gidx;
      end
      if (xfer && beat_last && RR == MODE_RR)
        ptr <= (gidx == SEL_W'(N-1)) ? '0 : gidx + 1'b1;
`ifdef RR_MUX_REG_LOCK_EN
      if (xfer) begin
        locked   <= !in_last[gidx];
        lock_ch  <= gidx;
        out_last <= in_last[gidx];
      end
`endif
    end
  end

endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed bench: round-robin instance (N=8) and fixed-priority instance (N=5).
module tb_rr_mux_reg;

  logic          clk = 1'b0;
  logic          rst;
  logic [255:0]  in_data;
  logic [7:0]    in_valid, in_ready, in_last;
  logic [31:0]   out_data;
  logic [2:0]    out_src;
  logic          out_valid, out_ready, out_last;

  logic [159:0]  in_data_f;
  logic [4:0]    in_valid_f, in_ready_f, in_last_f;
  logic [31:0]   out_data_f;
  logic [2:0]    out_src_f;
  logic          out_valid_f, out_last_f;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_mux_reg #(.WIDTH(32), .N(8), .RR(1)) u_rr (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready),
`ifdef RR_MUX_REG_LOCK_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  rr_mux_reg #(.WIDTH(32), .N(5), .RR(0)) u_fp (
    .clk(clk), .rst(rst), .in_data(in_data_f), .in_valid(in_valid_f),
    .in_ready(in_ready_f),
`ifdef RR_MUX_REG_LOCK_EN
    .in_last(in_last_f), .out_last(out_last_f),
`endif
    .out_data(out_data_f), .out_src(out_src_f), .out_valid(out_valid_f),
    .out_ready(1'b1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [2:0] src, input logic [31:0] d);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_src"}, 32'(out_src), 32'(src));
    chk({tag, "_data"}, out_data, d);
  endtask

  initial begin
    out_last = 1'b0;
    out_last_f = 1'b0;
    for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = 32'hA000_0000 + i;
    for (int i = 0; i < 5; i++) in_data_f[i*32 +: 32] = 32'hB000_0000 + i;
    rst = 1'b1; in_valid = 8'hFF; in_last = 8'hFF; out_ready = 1'b1;
    in_valid_f = 5'b11010; in_last_f = 5'h1F;

    // Reset held for two edges
    tick(); tick();
    chk("rst_ready", 32'(in_ready), 32'h00);
    chk_out("rst", 1'b0, 3'd0, 32'h0);
    chk("rst_ready_f", 32'(in_ready_f), 32'h00);
    rst = 1'b0;
    #1;
    chk("rel_ready", 32'(in_ready), 32'h01);
    chk("rel_ready_f", 32'(in_ready_f), 32'h02);

    // Round-robin sweep 0..7,0 then on to 3; fixed priority stays on channel 1
    for (int k = 0; k < 12; k++) begin
      tick();
      chk_out("sweep", 1'b1, 3'(k % 8), 32'hA000_0000 + (k % 8));
      chk("sweep_ready", 32'(in_ready), 32'(8'h01 << ((k + 1) % 8)));
      chk("fp_src", 32'(out_src_f), 32'd1);
      chk("fp_data", out_data_f, 32'hB000_0001);
      chk("fp_ready", 32'(in_ready_f), 32'h02);
    end

    // Backpressure holding src 3
    out_ready = 1'b0;
    #1;
    chk("bp_ready0", 32'(in_ready), 32'h00);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_out("bp_hold", 1'b1, 3'd3, 32'hA000_0003);
      chk("bp_ready", 32'(in_ready), 32'h00);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'h10);
    tick();
    chk_out("bp_after", 1'b1, 3'd4, 32'hA000_0004);
    tick();
    chk_out("to_ptr6", 1'b1, 3'd5, 32'hA000_0005);

    // Sparse request from pointer 6 wraps to 0, then 2
    in_valid = 8'b0000_0101;
    #1;
    chk("wrap_ready", 32'(in_ready), 32'h01);
    tick();
    chk_out("wrap0", 1'b1, 3'd0, 32'hA000_0000);
    chk("wrap_ready2", 32'(in_ready), 32'h04);
    tick();
    chk_out("wrap2", 1'b1, 3'd2, 32'hA000_0002);
    in_valid = 8'h00;
    #1;
    chk("idle_ready", 32'(in_ready), 32'h00);
    tick();
    chk_out("idle", 1'b0, 3'd2, 32'hA000_0002);

    // Reset while a word is held under backpressure
    in_valid = 8'hFF;
    #1;
    chk("pre_rst_ready", 32'(in_ready), 32'h08);
    tick();
    chk_out("pre_rst", 1'b1, 3'd3, 32'hA000_0003);
    out_ready = 1'b0; rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(in_ready), 32'h00);
    tick();
    chk_out("midrst", 1'b0, 3'd0, 32'h0);
    rst = 1'b0; out_ready = 1'b1; in_valid = 8'h24; in_last = 8'h00;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'h04);

`ifdef RR_MUX_REG_LOCK_EN
    tick();
    chk_out("lk_b0", 1'b1, 3'd2, 32'hA000_0002);
    chk("lk_last0", 32'(out_last), 32'd0);
    chk("lk_ready_b1", 32'(in_ready), 32'h04);
    in_valid = 8'h20;
    #1;
    chk("lk_gap_ready", 32'(in_ready), 32'h00);
    tick();
    chk("lk_gap_valid", 32'(out_valid), 32'd0);
    in_valid = 8'h24;
    #1;
    chk("lk_ready_b1b", 32'(in_ready), 32'h04);
    tick();
    chk_out("lk_b1", 1'b1, 3'd2, 32'hA000_0002);
    in_last = 8'h04;
    #1;
    chk("lk_ready_b2", 32'(in_ready), 32'h04);
    tick();
    chk_out("lk_b2", 1'b1, 3'd2, 32'hA000_0002);
    chk("lk_last1", 32'(out_last), 32'd1);
    // Pointer now 3: channel 5 wins over channel 0
    in_valid = 8'h21; in_last = 8'hFF;
    #1;
    chk("lk_ptr_ready", 32'(in_ready), 32'h20);
    tick();
    chk_out("lk_next", 1'b1, 3'd5, 32'hA000_0005);
`else
    tick();
    chk_out("post_rst", 1'b1, 3'd2, 32'hA000_0002);
    chk("post_rst_ready2", 32'(in_ready), 32'h20);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
